// File: rtl/sec_counter.sv
// Seconds counter 00..59 advanced by a DIV-cycle prescaler, with sync clear/load and pulse flags.
// Digits, carry_out and ld_err are registered (1-cycle latency); tick is combinational from pcnt/en.
module sec_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_units,
  input  logic [2:0] ld_tens,
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       tick,
  output logic       carry_out,
  output logic       ld_err
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic [3:0]    units_nxt;
  logic [2:0]    tens_nxt;
  logic          carry_nxt;
  logic          ld_err_nxt;
  logic          ld_ok;

  assign tick  = en && (pcnt == PMAX);
  assign ld_ok = (ld_units <= 4'd9) && (ld_tens <= 3'd5);

  // Priority: clr > load > tick > hold. Any load restarts the prescaler, valid or not.
  always_comb begin
    pcnt_nxt   = pcnt;
    units_nxt  = units;
    tens_nxt   = tens;
    carry_nxt  = 1'b0;
    ld_err_nxt = 1'b0;
    if (clr) begin
      pcnt_nxt  = '0;
      units_nxt = '0;
      tens_nxt  = '0;
    end else if (load) begin
      pcnt_nxt = '0;
      if (ld_ok) begin
        units_nxt = ld_units;
        tens_nxt  = ld_tens;
      end else begin
        ld_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (tick) begin
        pcnt_nxt = '0;
        if (units < 4'd9) begin
          units_nxt = units + 4'd1;
        end else begin
          units_nxt = '0;
          if (tens < 3'd5) begin
            tens_nxt = tens + 3'd1;
          end else begin
            tens_nxt  = '0;
            carry_nxt = 1'b1;
          end
        end
      end else begin
        pcnt_nxt = pcnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt      <= '0;
      units     <= '0;
      tens      <= '0;
      carry_out <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      pcnt      <= pcnt_nxt;
      units     <= units_nxt;
      tens      <= tens_nxt;
      carry_out <= carry_nxt;
      ld_err    <= ld_err_nxt;
    end
  end

  a_digit_range: assert property (@(posedge clk) disable iff (reset) (units <= 4'd9) && (tens <= 3'd5));
  a_pulse_excl:  assert property (@(posedge clk) disable iff (reset) !(carry_out && ld_err));

endmodule

// File: tb/tb_sec_counter.sv
// Directed bench for sec_counter (DIV=4): counting, enable hold, load/clear priority, async reset.
module tb_sec_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       load;
  logic [3:0] ld_units;
  logic [2:0] ld_tens;
  logic [3:0] units;
  logic [2:0] tens;
  logic       tick;
  logic       carry_out;
  logic       ld_err;

  int checks = 0;
  int passes = 0;

  sec_counter #(.DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .ld_units(ld_units), .ld_tens(ld_tens),
    .units(units), .tens(tens), .tick(tick), .carry_out(carry_out), .ld_err(ld_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; ld_units = 4'd0; ld_tens = 3'd0;
    #1 reset = 1'b1;
    #1;
    checks++; if ({tens, units, carry_out, ld_err} !== 9'd0) $display("FAIL reset_async: tens=%0d units=%0d carry=%b err=%b expected all 0", tens, units, carry_out, ld_err); else passes++;
    step(); step();
    checks++; if ({tens, units, carry_out, ld_err} !== 9'd0) $display("FAIL reset_held: tens=%0d units=%0d carry=%b err=%b expected all 0", tens, units, carry_out, ld_err); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_count();
    logic       exp_tick;
    logic [3:0] exp_units;
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      exp_tick  = (k % 4 == 0);
      exp_units = 4'(k / 4);
      #1;
      checks++; if (tick !== exp_tick) $display("FAIL count_tick cyc %0d: tick=%b expected %b", k, tick, exp_tick); else passes++;
      step();
      checks++; if (units !== exp_units || tens !== 3'd0) $display("FAIL count_digits cyc %0d: %0d%0d expected 0%0d", k, tens, units, exp_units); else passes++;
    end
  endtask

  // Starts at 03, pcnt=0, en=1.
  task automatic test_en_hold();
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    en = 1'b1;
    #1;
    checks++; if (tick !== 1'b0) $display("FAIL en_hold_early: tick=%b expected 0", tick); else passes++;
    step();
    #1;
    checks++; if (tick !== 1'b1) $display("FAIL en_hold_tick: tick=%b expected 1", tick); else passes++;
    step();
    checks++; if (units !== 4'd4 || tens !== 3'd0) $display("FAIL en_hold_digits: %0d%0d expected 04", tens, units); else passes++;
    en = 1'b0;
  endtask

  task automatic test_load_wrap();
    load = 1'b1; ld_tens = 3'd5; ld_units = 4'd9; en = 1'b1;
    step();
    load = 1'b0;
    checks++; if (units !== 4'd9 || tens !== 3'd5 || ld_err !== 1'b0) $display("FAIL load_valid: %0d%0d err=%b expected 59 err=0", tens, units, ld_err); else passes++;
    step(); step(); step();
    #1;
    checks++; if (tick !== 1'b1) $display("FAIL wrap_tick: tick=%b expected 1", tick); else passes++;
    step();
    en = 1'b0;
    checks++; if (units !== 4'd0 || tens !== 3'd0 || carry_out !== 1'b1) $display("FAIL wrap_carry: %0d%0d carry=%b expected 00 carry=1", tens, units, carry_out); else passes++;
    step();
    checks++; if (carry_out !== 1'b0) $display("FAIL wrap_carry_pulse: carry=%b expected 0", carry_out); else passes++;
  endtask

  // Starts at 00, pcnt=0.
  task automatic test_load_err();
    en = 1'b1;
    step(); step();
    load = 1'b1; ld_units = 4'd12; ld_tens = 3'd3;
    step();
    load = 1'b0;
    checks++; if (units !== 4'd0 || tens !== 3'd0 || ld_err !== 1'b1) $display("FAIL load_err: %0d%0d err=%b expected 00 err=1", tens, units, ld_err); else passes++;
    #1;
    checks++; if (tick !== 1'b0) $display("FAIL load_err_pcnt0: tick=%b expected 0", tick); else passes++;
    step();
    checks++; if (ld_err !== 1'b0) $display("FAIL load_err_pulse: err=%b expected 0", ld_err); else passes++;
    step(); step();
    #1;
    checks++; if (tick !== 1'b1) $display("FAIL load_err_restart: tick=%b expected 1", tick); else passes++;
    load = 1'b1; ld_units = 4'd2; ld_tens = 3'd6;
    step();
    load = 1'b0;
    checks++; if (units !== 4'd0 || tens !== 3'd0 || ld_err !== 1'b1) $display("FAIL load_err_tens: %0d%0d err=%b expected 00 err=1", tens, units, ld_err); else passes++;
  endtask

  // Starts at 00, pcnt=0, en=1.
  task automatic test_load_tick();
    step(); step(); step();
    load = 1'b1; ld_tens = 3'd3; ld_units = 4'd7;
    #1;
    checks++; if (tick !== 1'b1) $display("FAIL load_tick_pre: tick=%b expected 1", tick); else passes++;
    step();
    load = 1'b0;
    checks++; if (units !== 4'd7 || tens !== 3'd3) $display("FAIL load_tick_discard: %0d%0d expected 37", tens, units); else passes++;
    step(); step(); step(); step();
    checks++; if (units !== 4'd8 || tens !== 3'd3) $display("FAIL load_tick_resume: %0d%0d expected 38", tens, units); else passes++;
  endtask

  task automatic test_clr_load();
    load = 1'b1; ld_tens = 3'd5; ld_units = 4'd9; en = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    clr = 1'b1; load = 1'b1; ld_tens = 3'd2; ld_units = 4'd4;
    #1;
    checks++; if (tick !== 1'b1) $display("FAIL clr_load_pre: tick=%b expected 1", tick); else passes++;
    step();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    checks++; if (units !== 4'd0 || tens !== 3'd0 || ld_err !== 1'b0 || carry_out !== 1'b0) $display("FAIL clr_load: %0d%0d err=%b carry=%b expected 00 0 0", tens, units, ld_err, carry_out); else passes++;
    step();
    checks++; if (carry_out !== 1'b0 || ld_err !== 1'b0) $display("FAIL clr_load_after: carry=%b err=%b expected 0 0", carry_out, ld_err); else passes++;
  endtask

  task automatic test_reset_async();
    load = 1'b1; ld_tens = 3'd4; ld_units = 4'd7; en = 1'b1;
    step();
    load = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if (units !== 4'd0 || tens !== 3'd0) $display("FAIL reset_mid: %0d%0d expected 00", tens, units); else passes++;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (tick !== 1'b0) $display("FAIL reset_resume_tick cyc %0d: tick=%b expected 0", k, tick); else passes++;
      step();
    end
    step();
    checks++; if (units !== 4'd1 || tens !== 3'd0) $display("FAIL reset_resume: %0d%0d expected 01", tens, units); else passes++;
    // Reset landing on a carry pulse must kill it.
    load = 1'b1; ld_tens = 3'd5; ld_units = 4'd9;
    step();
    load = 1'b0;
    step(); step(); step(); step();
    checks++; if (carry_out !== 1'b1) $display("FAIL reset_carry_pre: carry=%b expected 1", carry_out); else passes++;
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (carry_out !== 1'b0) $display("FAIL reset_carry_kill: carry=%b expected 0", carry_out); else passes++;
    step();
    reset = 1'b0;
    step();
    checks++; if (carry_out !== 1'b0 || ld_err !== 1'b0 || units !== 4'd0) $display("FAIL reset_carry_after: carry=%b err=%b units=%0d expected 0 0 0", carry_out, ld_err, units); else passes++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_en_hold();
    test_load_wrap();
    test_load_err();
    test_load_tick();
    test_clr_load();
    test_reset_async();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sec_counter.md
SEC_COUNTER -- requirements
Module: sec_counter

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning enabled clock cycles per count tick; legal range 1..2^16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port en  input  1  count enable; prescaler and digits hold when low.
REQ-005 SHALL have port clr  input  1  synchronous clear of digits and prescaler.
REQ-006 SHALL have port load  input  1  synchronous load of digits from ld_units/ld_tens.
REQ-007 SHALL have port ld_units  input  4  BCD units value to load.
REQ-008 SHALL have port ld_tens  input  3  tens value to load.
REQ-009 SHALL have port units  output  4  registered units digit, 0..9.
REQ-010 SHALL have port tens  output  3  registered tens digit, 0..5.
REQ-011 SHALL have port tick  output  1  combinational prescaler tick, high when en=1 and prescaler count = DIV-1.
REQ-012 SHALL have port carry_out  output  1  registered one-cycle pulse on 59->00 wrap.
REQ-013 SHALL have port ld_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-014 SHALL hold a prescaler count pcnt of ceil(log2(DIV)) bits (min 1), range 0..DIV-1.
REQ-015 SHALL, when en=1 and no clr/load, advance pcnt by 1 per cycle, wrapping DIV-1 -> 0.
REQ-016 SHALL, with DIV=1, assert tick on every cycle where en=1.
REQ-017 SHALL apply per-edge priority: clr > load > tick > hold.
REQ-018 SHALL, on tick with units<9, increment units; tens unchanged.
REQ-019 SHALL, on tick with units=9 and tens<5, set units=0 and increment tens.
REQ-020 SHALL, on tick with units=9 and tens=5, set units=0, tens=0 and assert carry_out on the following cycle only.
REQ-021 SHALL make digit updates visible in the cycle after the tick edge (latency 1).
REQ-022 SHALL, on clr=1, set units=0, tens=0, pcnt=0; no carry_out, no ld_err; overrides simultaneous load and tick.
REQ-023 SHALL, on load=1 with ld_units<=9 and ld_tens<=5, load both digits, set pcnt=0, discard any simultaneous tick.
REQ-024 SHALL, on load=1 with ld_units>9 or ld_tens>5, leave digits unchanged, set pcnt=0, discard any simultaneous tick, pulse ld_err for one cycle.
REQ-025 SHALL process load and clr regardless of en.
REQ-026 SHALL keep carry_out and ld_err low except for their single-cycle pulses; never both high.
REQ-027 SHALL never present units>9 or tens>5 on outputs in any cycle.

Reset
REQ-028 SHALL, while reset=1, immediately force units=0, tens=0, pcnt=0, carry_out=0, ld_err=0, independent of clk.
REQ-029 SHALL, on reset assertion mid-count or during a load/carry pulse, abandon that operation with no pulse after release.
REQ-030 SHALL resume counting from 00, pcnt=0, on the first rising edge after reset deasserts with en=1.

Verification
REQ-031 SHALL cover: DIV=4, reset then en=1 for 12 cycles -> tick at cycles 4,8,12; units 1,2,3 after each; tens=0.
REQ-032 SHALL cover: load 5/9 (tens/units), then one tick -> units=0, tens=0, carry_out high exactly one cycle after the edge.
REQ-033 SHALL cover: load ld_units=12, ld_tens=3 -> digits unchanged, ld_err one-cycle pulse, pcnt=0.
REQ-034 SHALL cover: clr and valid load asserted together on a tick cycle -> units=0, tens=0, no ld_err, no carry_out.
REQ-035 SHALL cover: en toggled low for 3 cycles at pcnt=2 -> pcnt holds at 2, tick delayed exactly 3 cycles.
REQ-036 SHALL cover: reset asserted asynchronously between edges at count 47 -> outputs 00 before next edge; count 01 after DIV enabled cycles post-release.
